// File: rtl/boot_rom_bus_adapter_if.sv
// boot_rom_bus_adapter_if: requester-side TCDM bus plus ROM macro pins for the boot ROM adapter
interface boot_rom_bus_adapter_if #(parameter int ROM_ADDR_WIDTH = 13);
  logic                      req_i;
  logic                      gnt_o;
  logic [31:0]               add_i;
  logic                      we_i;
  logic [3:0]                be_i;
  logic [31:0]               wdata_i;
  logic                      r_valid_o;
  logic                      r_ready_i;
  logic [31:0]               r_rdata_o;
  logic                      r_opc_o;
  logic                      err_o;
  logic                      rom_csn_o;
  logic [ROM_ADDR_WIDTH-3:0] rom_add_o;
  logic [31:0]               rom_rdata_i;
  modport slave (
    input  req_i, add_i, we_i, be_i, wdata_i, r_ready_i, rom_rdata_i,
    output gnt_o, r_valid_o, r_rdata_o, r_opc_o, err_o, rom_csn_o, rom_add_o
  );
  modport master (
    output req_i, add_i, we_i, be_i, wdata_i, r_ready_i, rom_rdata_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_opc_o, err_o, rom_csn_o, rom_add_o
  );
endinterface

// File: rtl/boot_rom_bus_adapter.sv
// boot_rom_bus_adapter: req/gnt front end for the boot ROM with credit-limited, bypassing response FIFO
module boot_rom_bus_adapter #(
  parameter int          ROM_ADDR_WIDTH = 13,
  parameter logic [31:0] ROM_BASE       = 32'h1A00_0000,
  parameter int          RESP_DEPTH     = 2,
  parameter logic [31:0] ERR_DATA       = 32'hBADA_CCE5
) (
  input logic clk_i,
  input logic rst_i,
  boot_rom_bus_adapter_if.slave b
);
  localparam int PW = $clog2(RESP_DEPTH);
  logic          inflight, is_err, in_range, push, pop, empty;
  logic [PW:0]   occ;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [32:0]   mem [RESP_DEPTH];
  logic [32:0]   resp, head;
  logic          unused;
  assign unused   = ^{b.be_i, b.wdata_i, b.add_i[1:0]};
  assign in_range = b.add_i[31:ROM_ADDR_WIDTH] == ROM_BASE[31:ROM_ADDR_WIDTH];
  // Credits count both the response still in the ROM pipeline and the buffered ones
  assign b.gnt_o     = b.req_i & ~rst_i & ((32'(inflight) + 32'(occ)) < RESP_DEPTH);
  assign b.rom_csn_o = ~(b.gnt_o & ~b.we_i & in_range);
  assign b.rom_add_o = b.add_i[ROM_ADDR_WIDTH-1:2];
  assign resp        = {is_err, is_err ? ERR_DATA : b.rom_rdata_i};
  assign empty       = occ == '0;
  assign head        = empty ? resp : mem[rd_ptr];
  assign b.r_valid_o = inflight | ~empty;
  assign b.r_opc_o   = head[32];
  assign b.r_rdata_o = head[31:0];
  assign b.err_o     = is_err & inflight;
  assign pop         = ~empty & b.r_ready_i;
  assign push        = inflight & ~(empty & b.r_ready_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      is_err   <= 1'b0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= b.gnt_o;
      if (b.gnt_o) is_err <= b.we_i | ~in_range;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem[wr_ptr] <= resp;
  end
endmodule

// File: tb/tb_boot_rom_bus_adapter.sv
// tb_boot_rom_bus_adapter: directed plus random stimulus checked against an outstanding-response queue model
module tb_boot_rom_bus_adapter;
  localparam logic [31:0] BASE = 32'h1A00_0000;
  localparam logic [31:0] ERR  = 32'hBADA_CCE5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] rom_mem [2048];
  logic [32:0] q [$];
  bit last_err = 1'b0;
  boot_rom_bus_adapter_if #(.ROM_ADDR_WIDTH(13)) bus ();
  boot_rom_bus_adapter dut (.clk_i(clk), .rst_i(rst), .b(bus));
  always #5 clk = ~clk;
  // ROM macro: 1-cycle read latency, garbage when not selected
  always @(posedge clk) bus.rom_rdata_i <= !bus.rom_csn_o ? rom_mem[bus.rom_add_o] : $urandom;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit rq, input bit wr, input logic [31:0] a, input bit rdy, input bit rs);
    bit g, e;
    @(negedge clk);
    bus.req_i = rq;
    bus.we_i = wr;
    bus.add_i = a;
    bus.r_ready_i = rdy;
    bus.be_i = 4'($urandom);
    bus.wdata_i = $urandom;
    rst = rs;
    #1;
    e = wr || (a[31:13] != BASE[31:13]);
    g = rq && !rs && q.size() < 2;
    chk("gnt", 32'(bus.gnt_o), 32'(g));
    chk("rom_csn", 32'(bus.rom_csn_o), 32'(!(g && !e)));
    chk("rom_add", 32'(bus.rom_add_o), 32'(a[12:2]));
    chk("r_valid", 32'(bus.r_valid_o), 32'(q.size() > 0));
    chk("err", 32'(bus.err_o), 32'(last_err));
    if (q.size() > 0) begin
      chk("r_rdata", bus.r_rdata_o, q[0][31:0]);
      chk("r_opc", 32'(bus.r_opc_o), 32'(q[0][32]));
    end
    if (rs) begin
      q.delete();
      last_err = 1'b0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      last_err = g && e;
      if (g) q.push_back(e ? {1'b1, ERR} : {1'b0, rom_mem[a[12:2]]});
    end
  endtask
  initial begin
    logic [31:0] a;
    for (int i = 0; i < 2048; i++) rom_mem[i] = $urandom;
    rom_mem[4] = 32'hDEAD_BEEF;
    bus.req_i = 0; bus.we_i = 0; bus.add_i = 0; bus.r_ready_i = 0; bus.be_i = 0; bus.wdata_i = 0;
    step(1, 0, BASE, 1, 1);
    step(0, 0, BASE, 1, 1);
    step(1, 0, BASE + 32'h10, 1, 0);
    chk("dir_csn", 32'(bus.rom_csn_o), 32'd0);
    chk("dir_add", 32'(bus.rom_add_o), 32'd4);
    step(0, 0, BASE, 1, 0);
    chk("dir_rdata", bus.r_rdata_o, 32'hDEAD_BEEF);
    chk("dir_opc", 32'(bus.r_opc_o), 32'd0);
    for (int i = 0; i < 8; i++) step(1, 0, BASE + 32'(i * 4), 1, 0);
    step(0, 0, BASE, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, BASE + 32'(i * 4), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, BASE + 32'(i * 4), 1, 0);
    step(0, 0, BASE, 1, 0);
    step(0, 0, BASE, 1, 0);
    step(1, 1, BASE, 1, 0);
    chk("wr_csn", 32'(bus.rom_csn_o), 32'd1);
    step(0, 0, BASE, 1, 0);
    chk("wr_rdata", bus.r_rdata_o, ERR);
    chk("wr_err", 32'(bus.err_o), 32'd1);
    step(1, 0, BASE + 32'h20, 1, 0);
    step(1, 0, 32'h1B00_0000, 1, 0);
    step(1, 0, BASE + 32'h1FFC, 1, 0);
    step(1, 0, 32'h1A00_2000, 1, 0);
    step(1, 0, 32'h19FF_FFFC, 1, 0);
    step(0, 0, BASE, 1, 0);
    step(1, 0, BASE + 32'h40, 0, 0);
    step(1, 0, BASE + 32'h44, 0, 0);
    step(1, 0, BASE + 32'h48, 0, 0);
    step(1, 0, BASE + 32'h4C, 0, 0);
    step(1, 0, BASE + 32'h4C, 1, 1);
    step(0, 0, BASE, 1, 0);
    chk("rst_rvalid", 32'(bus.r_valid_o), 32'd0);
    step(1, 0, BASE + 32'h10, 1, 0);
    step(0, 0, BASE, 1, 0);
    chk("rst_rdata", bus.r_rdata_o, 32'hDEAD_BEEF);
    for (int i = 0; i < 3000; i++) begin
      a = BASE | ($urandom & 32'h1FFC);
      if ($urandom_range(7) == 0) a = $urandom;
      step($urandom_range(3) != 0, $urandom_range(7) == 0, a, $urandom_range(3) != 0, $urandom_range(199) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
